// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory stage and the data memory.
// The master side issues req/gnt/rvalid transactions.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I memory stage: turns EX/MEM loads/stores into dmem bus transactions,
// stalls upstream while outstanding, and registers the MEM/WB fields.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       rs2_data_in,
  input  logic [2:0]        funct3_in,
  input  logic [4:0]        rd_in,
  input  logic [1:0]        wb_sel_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  mem_access_unit_if.master dmem,
  output logic              mem_stall,
  output logic              misalign,
  output logic              bus_err,
  output logic [31:0]       wb_pc,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic [1:0]        wb_sel,
  output logic              wb_reg_write
);
  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [7:0] LastCnt = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, pc_q, data_q;
  logic [3:0]  be_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [1:0]  sel_q;
  logic        we_q, rw_q, fail_q;

  logic        access, legal, aligned, bad, start, timeout, load_done;
  logic [1:0]  off;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Decode of the instruction currently sitting in EX/MEM.
  always_comb begin
    access = mem_read_in | mem_write_in;
    off    = alu_result_in[1:0];
    if (mem_read_in) legal = funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else             legal = funct3_in inside {3'b000, 3'b001, 3'b010};
    case (funct3_in[1:0])
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    bad   = access & ~(legal & aligned);
    start = (state_q == StIdle) & access & ~bad;
    case (funct3_in[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << off;
        wdata_calc = {4{rs2_data_in[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << off;
        wdata_calc = {2{rs2_data_in[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = rs2_data_in;
      end
    endcase
  end

  always_comb begin
    ld_byte = dmem.dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'b0, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'b0, ld_half};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  // The timeout counter spans REQ and WAIT together.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout   = 1'b0;
    load_done = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) state_d = StReq;
      end
      StReq: begin
        if (dmem.dmem_gnt) begin
          state_d = we_q ? StDone : StWait;
          cnt_d   = we_q ? 8'd0 : cnt_q + 8'd1;
        end else if (cnt_q >= LastCnt) begin
          timeout = 1'b1;
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWait: begin
        if (dmem.dmem_rvalid) begin
          load_done = 1'b1;
          state_d   = StDone;
          cnt_d     = '0;
        end else if (cnt_q >= LastCnt) begin
          timeout = 1'b1;
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_stall       = start | (state_q == StReq) | (state_q == StWait);
  assign dmem.dmem_req   = (state_q == StReq);
  assign dmem.dmem_we    = dmem.dmem_req & we_q;
  assign dmem.dmem_be    = dmem.dmem_req ? be_q : 4'b0000;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      rd_q     <= '0;
      pc_q     <= '0;
      sel_q    <= '0;
      rw_q     <= 1'b0;
      data_q   <= '0;
      fail_q   <= 1'b0;
    end else begin
      if (start) begin
        addr_q   <= alu_result_in;
        be_q     <= be_calc;
        wdata_q  <= wdata_calc;
        we_q     <= ~mem_read_in;
        funct3_q <= funct3_in;
        rd_q     <= rd_in;
        pc_q     <= pc_in;
        sel_q    <= wb_sel_in;
        rw_q     <= reg_write_in;
        data_q   <= alu_result_in;
        fail_q   <= 1'b0;
      end
      if (load_done) data_q <= load_ext;
      if (timeout)   fail_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
      wb_pc        <= '0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_sel       <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      misalign <= (state_q == StIdle) & bad;
      bus_err  <= timeout;
      if (state_q == StDone) begin
        wb_pc        <= pc_q;
        wb_data      <= data_q;
        wb_rd        <= rd_q;
        wb_sel       <= sel_q;
        wb_reg_write <= rw_q & ~fail_q;
      end else if (mem_stall) begin
        wb_reg_write <= 1'b0;
      end else begin
        wb_pc        <= pc_in;
        wb_data      <= alu_result_in;
        wb_rd        <= rd_in;
        wb_sel       <= wb_sel_in;
        wb_reg_write <= reg_write_in & ~bad;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected MEM/WB
// entries, a monitor pops them as instructions retire; a responder models memory.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, alu_result_in, rs2_data_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic [1:0]  wb_sel_in;
  logic        mem_read_in, mem_write_in, reg_write_in;
  logic        mem_stall, misalign, bus_err, wb_reg_write;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;

  mem_access_unit_if bus ();

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .alu_result_in(alu_result_in),
    .rs2_data_in  (rs2_data_in),
    .funct3_in    (funct3_in),
    .rd_in        (rd_in),
    .wb_sel_in    (wb_sel_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .reg_write_in (reg_write_in),
    .dmem         (bus.master),
    .mem_stall    (mem_stall),
    .misalign     (misalign),
    .bus_err      (bus_err),
    .wb_pc        (wb_pc),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_sel       (wb_sel),
    .wb_reg_write (wb_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        rw;
    logic        mis;
    logic        chk;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory responder configuration
  int          gnt_dly = 0, rv_dly = 0;
  bit          gnt_never = 1'b0, rv_never = 1'b0, manual = 1'b0, force_rv = 1'b0;
  logic [31:0] rd_word = '0;
  int          rq_n = 0, rv_n = 0;
  bit          pend = 1'b0;

  always @(negedge clk) begin
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = rd_word;
    if (rst) begin
      rq_n = 0;
      pend = 1'b0;
    end else if (manual) begin
      bus.dmem_rvalid = force_rv;
    end else begin
      if (pend) begin
        if (!rv_never && rv_n == rv_dly) begin
          bus.dmem_rvalid = 1'b1;
          pend = 1'b0;
        end else rv_n++;
      end
      if (bus.dmem_req) begin
        if (!gnt_never && rq_n == gnt_dly) begin
          bus.dmem_gnt = 1'b1;
          pend = !bus.dmem_we;
          rv_n = 0;
          rq_n = 0;
        end else rq_n++;
      end else rq_n = 0;
    end
  end

  // Expected bus fields for the current access
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  logic        exp_we = 1'b0;
  int n_stall = 0, n_req = 0, n_err = 0, n_mis = 0;
  bit prev_ok = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && prev_ok && wb_pc != 32'h0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_retire: got pc %h want none", wb_pc);
      end else begin
        e = q.pop_front();
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        chk("misalign_at_retire", 32'(misalign), 32'(e.mis));
        if (e.chk) begin
          chk("wb_data", wb_data, e.data);
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_sel", 32'(wb_sel), 32'(e.sel));
        end
      end
    end
    prev_ok = !rst && !mem_stall;
    if (mem_stall)    n_stall++;
    if (bus.dmem_req) n_req++;
    if (bus_err)      n_err++;
    if (misalign)     n_mis++;
    if (bus.dmem_req) begin
      chk("dmem_addr", bus.dmem_addr, exp_addr);
      chk("dmem_be", 32'(bus.dmem_be), 32'(exp_be));
      chk("dmem_we", 32'(bus.dmem_we), 32'(exp_we));
      if (exp_we) chk("dmem_wdata", bus.dmem_wdata, exp_wdata);
    end else begin
      chk("idle_be", 32'(bus.dmem_be), 32'h0);
      chk("idle_we", 32'(bus.dmem_we), 32'h0);
    end
  end

  task automatic nop();
    pc_in = '0; alu_result_in = '0; rs2_data_in = '0; funct3_in = '0; rd_in = '0;
    wb_sel_in = '0; mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0;
  endtask

  task automatic run(input string nm, input logic [31:0] pc, input logic [31:0] addr,
                     input logic [31:0] rs2, input logic [2:0] f3, input logic mr,
                     input logic mw, input logic rw, input logic [4:0] rdv,
                     input logic [1:0] sel, input int gd, input int rdl, input bit gnev,
                     input logic [31:0] word, input logic [3:0] be, input logic [31:0] wd,
                     input logic [31:0] wbd, input logic chkd, input logic erw,
                     input logic emis, input int s_exp, input int r_exp, input int e_exp,
                     input int m_exp);
    exp_t e;
    bit   done;
    int   s0, r0, e0, m0;
    @(posedge clk);
    #1;
    gnt_dly = gd; rv_dly = rdl; gnt_never = gnev; rv_never = 1'b0; rd_word = word;
    exp_addr = {addr[31:2], 2'b00}; exp_be = be; exp_we = mw & !mr; exp_wdata = wd;
    s0 = n_stall; r0 = n_req; e0 = n_err; m0 = n_mis;
    e = '{pc: pc, data: wbd, rd: rdv, sel: sel, rw: erw, mis: emis, chk: chkd};
    q.push_back(e);
    pc_in = pc; alu_result_in = addr; rs2_data_in = rs2; funct3_in = f3; rd_in = rdv;
    wb_sel_in = sel; mem_read_in = mr; mem_write_in = mw; reg_write_in = rw;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!mem_stall) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_stall_bound: got stall stuck want release", nm);
    end
    @(posedge clk);
    #1;
    nop();
    repeat (2) @(negedge clk);
    chk({nm, "_stall_cycles"}, 32'(n_stall - s0), 32'(s_exp));
    chk({nm, "_req_cycles"}, 32'(n_req - r0), 32'(r_exp));
    chk({nm, "_bus_err_cycles"}, 32'(n_err - e0), 32'(e_exp));
    chk({nm, "_misalign_cycles"}, 32'(n_mis - m0), 32'(m_exp));
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    nop();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.dmem_req), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_wb_pc", wb_pc, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rw", 32'(wb_reg_write), 32'h0);
    chk("rst_errs", 32'({misalign, bus_err}), 32'h0);
    rst = 1'b0;

    //  name   pc        addr      rs2        f3    mr mw rw rd sel gd rd nev rdata     be
    //         wdata     wbdata    chk erw mis stall req err mis
    run("alu", 32'h1000, 32'h1234, 32'h0, 3'b000, 0, 0, 1, 5, 2'd0, 0, 0, 0, 32'h0, 4'h0,
        32'h0, 32'h1234, 1, 1, 0, 0, 0, 0, 0);
    run("lb", 32'h1004, 32'h103, 32'h0, 3'b000, 1, 0, 1, 6, 2'd1, 0, 0, 0, 32'h80FF0000,
        4'b1000, 32'h0, 32'hFFFFFF80, 1, 1, 0, 3, 1, 0, 0);
    run("lbu", 32'h1008, 32'h103, 32'h0, 3'b100, 1, 0, 1, 6, 2'd1, 0, 0, 0, 32'h80FF0000,
        4'b1000, 32'h0, 32'h00000080, 1, 1, 0, 3, 1, 0, 0);
    run("sh", 32'h100C, 32'h202, 32'hABCD1234, 3'b001, 0, 1, 0, 0, 2'd0, 3, 0, 0, 32'h0,
        4'b1100, 32'h12341234, 32'h202, 1, 0, 0, 5, 4, 0, 0);
    run("lw_mis", 32'h1010, 32'h101, 32'h0, 3'b010, 1, 0, 1, 8, 2'd1, 0, 0, 0, 32'h0,
        4'h0, 32'h0, 32'h0, 0, 0, 1, 0, 0, 0, 1);
    run("ld_f3_011", 32'h1014, 32'h100, 32'h0, 3'b011, 1, 0, 1, 8, 2'd1, 0, 0, 0, 32'h0,
        4'h0, 32'h0, 32'h0, 0, 0, 1, 0, 0, 0, 1);
    run("st_f3_100", 32'h1018, 32'h0, 32'h55, 3'b100, 0, 1, 0, 0, 2'd0, 0, 0, 0, 32'h0,
        4'h0, 32'h0, 32'h0, 0, 0, 1, 0, 0, 0, 1);
    run("timeout", 32'h101C, 32'h400, 32'h0, 3'b010, 1, 0, 1, 9, 2'd1, 0, 0, 1, 32'h0,
        4'b1111, 32'h0, 32'h0, 0, 0, 0, 5, 4, 1, 0);
    run("lh_slow", 32'h1020, 32'h102, 32'h0, 3'b001, 1, 0, 1, 10, 2'd1, 1, 1, 0,
        32'h80011234, 4'b1100, 32'h0, 32'hFFFF8001, 1, 1, 0, 5, 2, 0, 0);
    run("lhu", 32'h1024, 32'h102, 32'h0, 3'b101, 1, 0, 1, 11, 2'd1, 0, 0, 0, 32'h80011234,
        4'b1100, 32'h0, 32'h00008001, 1, 1, 0, 3, 1, 0, 0);
    run("sb", 32'h1028, 32'h301, 32'h000000AB, 3'b000, 0, 1, 0, 0, 2'd0, 0, 0, 0, 32'h0,
        4'b0010, 32'hABABABAB, 32'h301, 1, 0, 0, 2, 1, 0, 0);
    run("sw", 32'h102C, 32'h300, 32'h11223344, 3'b010, 0, 1, 0, 0, 2'd0, 0, 0, 0, 32'h0,
        4'b1111, 32'h11223344, 32'h300, 1, 0, 0, 2, 1, 0, 0);

    // Reset while a load is waiting for rvalid; the access must vanish.
    @(posedge clk);
    #1;
    gnt_dly = 0; gnt_never = 1'b0; rv_never = 1'b1;
    exp_addr = 32'h180; exp_be = 4'b1111; exp_we = 1'b0;
    pc_in = 32'h2000; alu_result_in = 32'h180; funct3_in = 3'b010; rd_in = 5'd12;
    mem_read_in = 1'b1; reg_write_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.dmem_req) seen = 1'b1;
    end
    chk("rst_test_req_seen", 32'(seen), 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    nop();
    #1;
    chk("midrst_req", 32'(bus.dmem_req), 32'h0);
    chk("midrst_stall", 32'(mem_stall), 32'h0);
    chk("midrst_wb_rw", 32'(wb_reg_write), 32'h0);
    chk("midrst_wb_pc", wb_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    manual = 1'b1;
    force_rv = 1'b1;
    @(posedge clk);
    #1;
    manual = 1'b0;
    force_rv = 1'b0;
    chk("late_rvalid_stall", 32'(mem_stall), 32'h0);
    chk("late_rvalid_wb_rw", 32'(wb_reg_write), 32'h0);
    chk("late_rvalid_wb_pc", wb_pc, 32'h0);

    run("lw_after_rst", 32'h2004, 32'h200, 32'h0, 3'b010, 1, 0, 1, 13, 2'd1, 0, 1, 0,
        32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF, 1, 1, 0, 4, 1, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
